// File: rtl/student_number_sequencer.sv
// student_number_sequencer: streams stored BCD student numbers, MSD first, starting from the selected client
module student_number_sequencer #(
    parameter int NUM_STUDENTS = 2,
    parameter int DIGITS = 7,
    parameter int SEL_W = 1,
    parameter logic [4*DIGITS*NUM_STUDENTS-1:0] STUDENT_IDS = 56'h2049719_2046019
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [SEL_W-1:0] ClientSel,
    input  logic             Abort,
    output logic [3:0]       Digit,
    output logic             DigitValid,
    input  logic             DigitReady,
    output logic             LastDigit,
    output logic             Busy,
    output logic             Done,
    output logic             Error
);
    localparam int N = NUM_STUDENTS * DIGITS;
    localparam int IDX_W = $clog2(N + 1);
    localparam int CNT_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} stateType;

    stateType state;
    logic [SEL_W-1:0] stuPtr, nextPtr;
    logic [CNT_W-1:0] digCnt, nextCnt;
    logic [IDX_W-1:0] idx;
    logic handshake, lastCnt, selOk;

    function automatic logic [3:0] digitAt(input logic [SEL_W-1:0] p, input logic [CNT_W-1:0] c);
        return STUDENT_IDS[int'(p) * 4 * DIGITS + (DIGITS - 1 - int'(c)) * 4 +: 4];
    endfunction

    // position of the digit that follows the one currently presented
    always_comb begin
        handshake = state == STREAM && DigitValid && DigitReady;
        lastCnt = digCnt == CNT_W'(DIGITS - 1);
        nextCnt = lastCnt ? '0 : digCnt + CNT_W'(1);
        nextPtr = !lastCnt ? stuPtr : (stuPtr == SEL_W'(NUM_STUDENTS - 1) ? '0 : stuPtr + SEL_W'(1));
        selOk = int'(ClientSel) < NUM_STUDENTS;
    end

    // control FSM with registered stream outputs; the next digit is preloaded on each handshake so there is no bubble
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state <= IDLE;
            stuPtr <= '0;
            digCnt <= '0;
            idx <= '0;
            Digit <= '0;
            DigitValid <= 1'b0;
            LastDigit <= 1'b0;
            Busy <= 1'b0;
            Done <= 1'b0;
            Error <= 1'b0;
        end else begin
            Done <= 1'b0;
            Error <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start && selOk) begin
                        state <= STREAM;
                        stuPtr <= ClientSel;
                        digCnt <= '0;
                        idx <= '0;
                        Digit <= digitAt(ClientSel, '0);
                        DigitValid <= 1'b1;
                        LastDigit <= 1'b0;
                        Busy <= 1'b1;
                    end else if (Start) begin
                        Error <= 1'b1;
                    end
                end
                STREAM: begin
                    if (Abort) begin
                        state <= IDLE;
                        Digit <= '0;
                        DigitValid <= 1'b0;
                        LastDigit <= 1'b0;
                        Busy <= 1'b0;
                    end else if (handshake && LastDigit) begin
                        state <= DONE;
                        Digit <= '0;
                        DigitValid <= 1'b0;
                        LastDigit <= 1'b0;
                        Done <= 1'b1;
                    end else if (handshake) begin
                        stuPtr <= nextPtr;
                        digCnt <= nextCnt;
                        idx <= idx + IDX_W'(1);
                        Digit <= digitAt(nextPtr, nextCnt);
                        LastDigit <= idx == IDX_W'(N - 2);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_student_number_sequencer.sv
// tb_student_number_sequencer: scoreboard bench for the default and a three-student configuration
module tb_student_number_sequencer;
    logic Clock = 1'b0;
    logic ResetN = 1'b0;
    logic StartA = 1'b0, SelA = 1'b0, AbortA = 1'b0, ReadyA = 1'b0;
    logic [3:0] DigitA;
    logic ValidA, LastA, BusyA, DoneA, ErrorA;
    logic StartB = 1'b0, AbortB = 1'b0, ReadyB = 1'b0;
    logic [1:0] SelB = 2'd0;
    logic [3:0] DigitB;
    logic ValidB, LastB, BusyB, DoneB, ErrorB;

    int checks = 0;
    int failures = 0;
    int doneCntA = 0;
    logic [4:0] qA[$];
    logic [4:0] qB[$];

    always #5 Clock = ~Clock;

    student_number_sequencer dutA (
        .Clock(Clock), .ResetN(ResetN), .Start(StartA), .ClientSel(SelA), .Abort(AbortA),
        .Digit(DigitA), .DigitValid(ValidA), .DigitReady(ReadyA), .LastDigit(LastA),
        .Busy(BusyA), .Done(DoneA), .Error(ErrorA)
    );

    student_number_sequencer #(
        .NUM_STUDENTS(3), .DIGITS(7), .SEL_W(2), .STUDENT_IDS(84'h2222222_1111111_0000000)
    ) dutB (
        .Clock(Clock), .ResetN(ResetN), .Start(StartB), .ClientSel(SelB), .Abort(AbortB),
        .Digit(DigitB), .DigitValid(ValidB), .DigitReady(ReadyB), .LastDigit(LastB),
        .Busy(BusyB), .Done(DoneB), .Error(ErrorB)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor A: every presented digit must match the scoreboard head; pop only on an accepted handshake
    always @(negedge Clock) begin
        if (ResetN && DoneA) doneCntA++;
        if (ResetN && ValidA && !AbortA) begin
            checks++;
            if (qA.size() == 0) begin
                failures++;
                $display("FAIL digitA: got %0d last=%0b expected no digit", DigitA, LastA);
            end else begin
                if ({LastA, DigitA} !== qA[0] || !BusyA) begin
                    failures++;
                    $display("FAIL digitA: got last=%0b digit=%0d busy=%0b expected last=%0b digit=%0d busy=1",
                             LastA, DigitA, BusyA, qA[0][4], qA[0][3:0]);
                end
                if (ReadyA) void'(qA.pop_front());
            end
        end
    end

    // monitor B: same scoreboard discipline for the three-student instance
    always @(negedge Clock) begin
        if (ResetN && ValidB) begin
            checks++;
            if (qB.size() == 0) begin
                failures++;
                $display("FAIL digitB: got %0d last=%0b expected no digit", DigitB, LastB);
            end else begin
                if ({LastB, DigitB} !== qB[0]) begin
                    failures++;
                    $display("FAIL digitB: got last=%0b digit=%0d expected last=%0b digit=%0d",
                             LastB, DigitB, qB[0][4], qB[0][3:0]);
                end
                if (ReadyB) void'(qB.pop_front());
            end
        end
    end

    int seq0[14] = '{2, 0, 4, 6, 0, 1, 9, 2, 0, 4, 9, 7, 1, 9};
    int seq1[14] = '{2, 0, 4, 9, 7, 1, 9, 2, 0, 4, 6, 0, 1, 9};

    task automatic pushA(input logic sel, input int count);
        for (int i = 0; i < count; i++)
            qA.push_back({i == 13, sel ? 4'(seq1[i]) : 4'(seq0[i])});
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0 repeating; restartAt re-pulses Start mid-stream
    task automatic runA(input logic sel, input int mode, input int restartAt, output int cyc);
        SelA = sel;
        StartA = 1'b1;
        @(posedge Clock);
        #1 StartA = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            ReadyA = mode == 0 ? 1'b1 : (cyc % 3 == 0);
            StartA = cyc == restartAt;
            @(negedge Clock);
            if (DoneA) break;
            cyc++;
            @(posedge Clock);
            #1;
        end
        StartA = 1'b0;
        if (cyc >= 200) chk("doneTimeoutA", 0, 1);
    endtask

    initial begin
        int cyc;
        int doneBase;
        repeat (2) @(posedge Clock);
        #1;
        chk("resetOutA", {DigitA, ValidA, LastA, BusyA, DoneA, ErrorA}, 0);
        chk("resetOutB", {DigitB, ValidB, LastB, BusyB, DoneB, ErrorB}, 0);
        ResetN = 1'b1;
        @(posedge Clock);
        #1;

        pushA(1'b0, 14);
        runA(1'b0, 0, -1, cyc);
        chk("fullRateCycles0", cyc, 14);
        chk("queueEmpty0", qA.size(), 0);
        chk("busyDuringDone", BusyA, 1);
        @(negedge Clock);
        chk("busyAfterDone", {BusyA, DoneA, ValidA}, 0);

        pushA(1'b1, 14);
        runA(1'b1, 1, -1, cyc);
        chk("stallCycles1", cyc, 40);
        chk("queueEmpty1", qA.size(), 0);
        @(posedge Clock);
        #1 ReadyA = 1'b1;

        pushA(1'b0, 4);
        for (int i = 0; i < 4; i++) qA[i][4] = 1'b0;
        SelA = 1'b0;
        StartA = 1'b1;
        @(posedge Clock);
        #1 StartA = 1'b0;
        repeat (4) @(posedge Clock);
        #1 AbortA = 1'b1;
        @(negedge Clock);
        chk("abortDigit5", DigitA, 0);
        @(posedge Clock);
        #1 AbortA = 1'b0;
        @(negedge Clock);
        chk("abortOut", {ValidA, DoneA, ErrorA, BusyA}, 0);
        chk("abortQueue", qA.size(), 0);
        pushA(1'b0, 14);
        runA(1'b0, 0, -1, cyc);
        chk("restartCycles", cyc, 14);
        chk("restartQueue", qA.size(), 0);

        @(posedge Clock);
        #1;
        pushA(1'b1, 14);
        SelA = 1'b1;
        StartA = 1'b1;
        @(posedge Clock);
        #1 StartA = 1'b0;
        repeat (3) @(posedge Clock);
        #2 ResetN = 1'b0;
        #1;
        chk("asyncReset", {DigitA, ValidA, LastA, BusyA, DoneA, ErrorA}, 0);
        qA.delete();
        repeat (2) @(posedge Clock);
        #1 ResetN = 1'b1;
        repeat (4) @(negedge Clock);
        chk("idleAfterReset", {ValidA, BusyA, DoneA}, 0);

        @(posedge Clock);
        #1;
        doneBase = doneCntA;
        pushA(1'b0, 14);
        runA(1'b0, 0, 3, cyc);
        chk("restartIgnoredCycles", cyc, 14);
        StartA = 1'b1;
        SelA = 1'b1;
        @(posedge Clock);
        #1 StartA = 1'b0;
        @(negedge Clock);
        chk("startInDoneIgnored", {ValidA, BusyA}, 0);
        repeat (2) @(negedge Clock);
        chk("singleDone", doneCntA - doneBase, 1);
        chk("queueEmpty6", qA.size(), 0);

        @(posedge Clock);
        #1;
        SelB = 2'd3;
        StartB = 1'b1;
        @(posedge Clock);
        #1 StartB = 1'b0;
        @(negedge Clock);
        chk("errorPulse", {ErrorB, ValidB, BusyB}, 3'b100);
        @(negedge Clock);
        chk("errorOneCycle", {ErrorB, ValidB, BusyB}, 0);

        for (int i = 0; i < 21; i++) qB.push_back({i == 20, i < 7 ? 4'd2 : (i < 14 ? 4'd0 : 4'd1)});
        @(posedge Clock);
        #1;
        SelB = 2'd2;
        ReadyB = 1'b1;
        StartB = 1'b1;
        @(posedge Clock);
        #1 StartB = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge Clock);
            if (DoneB) break;
            cyc++;
        end
        chk("threeStudentCycles", cyc, 21);
        chk("queueEmptyB", qB.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/student_number_sequencer.md
Name: student_number_sequencer

Overview:
- Parametrised successor to the fixed two-client student-number selector.
- Holds NUM_STUDENTS hard-coded decimal student numbers as packed BCD.
- On a start request for a selected client, serially emits the concatenated digits, MSD first, over a valid/ready stream. The client's own number goes first, then the remaining numbers in cyclic order.
- Sits between client selection logic and the downstream barcode symbol encoder.

Parameters:
NUM_STUDENTS, 2, number of stored student numbers (>=2)
DIGITS, 7, decimal digits per student number
SEL_W, 1, width of ClientSel; 2**SEL_W >= NUM_STUDENTS
STUDENT_IDS, 56'h2049719_2046019, packed BCD, width 4*DIGITS*NUM_STUDENTS; student i at bits [i*4*DIGITS +: 4*DIGITS]

Ports:
Clock  input  1  system clock, rising edge
ResetN  input  1  asynchronous reset, active-low
Start  input  1  request a sequence; sampled only in IDLE
ClientSel  input  SEL_W  client index; sampled with Start
Abort  input  1  synchronous abort of a running sequence
Digit  output  4  current BCD digit
DigitValid  output  1  Digit is valid
DigitReady  input  1  consumer accepts Digit when DigitValid && DigitReady at a rising edge
LastDigit  output  1  Digit is the final digit of the sequence; qualified by DigitValid
Busy  output  1  high in STREAM and DONE
Done  output  1  one-cycle pulse after the last digit is accepted
Error  output  1  one-cycle pulse on Start with an invalid ClientSel

Behaviour:
- Reset (ResetN=0, asynchronous): state=IDLE. Digit, DigitValid, LastDigit, Busy, Done and Error are all 0. Internal counters are cleared. Reset takes effect immediately, including mid-stream. No partial stream resumes after release.
- Total digits per sequence: N = NUM_STUDENTS*DIGITS. Sequence order: student s, s+1, ..., wrapping modulo NUM_STUDENTS, where s = ClientSel. Each number is sent MSD first.
- State IDLE:
  - Start=1 and ClientSel<NUM_STUDENTS: latch s and go to STREAM. In the next cycle DigitValid=1, Digit = first digit, and Busy=1. Latency from the Start edge to the first valid digit is 1 cycle.
  - Start=1 and ClientSel>=NUM_STUDENTS: Error=1 for one cycle and the state stays IDLE.
  - Abort is ignored in IDLE.
- State STREAM:
  - Digit and LastDigit stay stable while DigitValid && !DigitReady.
  - On handshake, advance to the next digit in the following cycle. No bubble is allowed: with DigitReady held at 1, one digit is sent per cycle.
  - Digit index counter runs 0..N-1. Within each number, the digit counter runs 0..DIGITS-1, then the student pointer increments with wrap.
  - LastDigit=1 exactly when the index is N-1.
  - A handshake on the last digit moves the state to DONE; DigitValid drops in that next cycle.
  - Abort=1 (takes priority over a handshake in the same cycle): go to IDLE next cycle. DigitValid=0, no Done, no Error. A digit presented in the abort cycle counts as not accepted.
  - Start is ignored while Busy.
- State DONE: Done=1 and Busy=1 for exactly one cycle, then IDLE. Start in DONE is ignored.
- Stored nibbles are emitted verbatim. No BCD validity check is made on STUDENT_IDS.
- The block contains no combinational path from DigitReady to DigitValid. DigitValid is registered.

Test Plan:
- Defaults, ClientSel=0, pulse Start, DigitReady=1 -> DigitValid high for 14 consecutive cycles starting 1 cycle after Start. Digits: 2,0,4,6,0,1,9,2,0,4,9,7,1,9. LastDigit on the 14th digit only. Done pulses the next cycle; Busy falls after Done.
- Defaults, ClientSel=1, DigitReady toggled 1,0,0,1,... -> digits 2,0,4,9,7,1,9,2,0,4,6,0,1,9. Digit is held stable across every stall cycle, and no digit is duplicated or skipped.
- NUM_STUDENTS=3, SEL_W=2, STUDENT_IDS={2222222,1111111,0000000} with student 0 in the LSBs, ClientSel=2 -> seven 2s, seven 0s, seven 1s, with LastDigit on the 21st digit. ClientSel=3 -> Error pulse of 1 cycle, DigitValid stays 0, Busy stays 0.
- Abort asserted during the 5th digit with DigitReady=1 -> DigitValid=0 the next cycle, no Done. A fresh Start with ClientSel=0 then restarts the sequence from digit 2.
- ResetN driven low asynchronously mid-stream (between clock edges) -> all outputs 0 immediately. After release with Start=0, the block stays idle with no output.
- Start re-pulsed during STREAM and during DONE -> ignored. The sequence completes unchanged with exactly one Done pulse.
